// File: rtl/tb_main.sv
// Four-register Wishbone slave with byte-lane writes and zero-wait-state ack.
// Read data is combinational; unmapped addresses read zero and ignore writes.
module tb_main #(
  parameter int WB_ADR_BITS = 38,
  parameter int WB_DAT_BITS = 32,
  parameter int WB_SEL_BITS = WB_DAT_BITS / 8,
  parameter logic [WB_DAT_BITS-1:0] INIT0 = '0,
  parameter logic [WB_DAT_BITS-1:0] INIT1 = '0,
  parameter logic [WB_DAT_BITS-1:0] INIT2 = '0,
  parameter logic [WB_DAT_BITS-1:0] INIT3 = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WB_ADR_BITS-1:0] s_wb_adr_i,
  output logic [WB_DAT_BITS-1:0] s_wb_dat_o,
  input  logic [WB_DAT_BITS-1:0] s_wb_dat_i,
  input  logic [WB_SEL_BITS-1:0] s_wb_sel_i,
  input  logic                   s_wb_we_i,
  input  logic                   s_wb_stb_i,
  output logic                   s_wb_ack_o
);

  localparam logic [WB_DAT_BITS-1:0] INIT_V [4] =
    '{INIT0, INIT1, INIT2, INIT3};

  logic [WB_DAT_BITS-1:0] regs [4];
  logic                   mapped;
  logic [1:0]             idx;
  logic                   wr_en;

  // Upper address bits must all be zero: no aliasing above word 3.
  assign mapped = (s_wb_adr_i[WB_ADR_BITS-1:2] == '0);
  assign idx    = s_wb_adr_i[1:0];
  assign wr_en  = s_wb_stb_i & s_wb_we_i & mapped;

  assign s_wb_ack_o = s_wb_stb_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 4; r++)
        regs[r] <= INIT_V[r];
    end else if (wr_en) begin
      for (int b = 0; b < WB_SEL_BITS; b++)
        if (s_wb_sel_i[b])
          regs[idx][8*b +: 8] <= s_wb_dat_i[8*b +: 8];
    end
  end

  always_comb begin
    s_wb_dat_o = '0;
    if (mapped)
      s_wb_dat_o = regs[idx];
  end

endmodule

// File: tb/tb_tb_main.sv
// Directed bench for tb_main: reset values, full/byte writes,
// unmapped accesses, null-select writes, async reset and read-during-write.
module tb_tb_main;

  logic        clk;
  logic        reset;
  logic [37:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        ack;

  int n_cmp;
  int n_err;

  tb_main dut (
    .clk        (clk),
    .reset      (reset),
    .s_wb_adr_i (adr),
    .s_wb_dat_o (dat_o),
    .s_wb_dat_i (dat_i),
    .s_wb_sel_i (sel),
    .s_wb_we_i  (we),
    .s_wb_stb_i (stb),
    .s_wb_ack_o (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle write; called just after a falling edge.
  task automatic wr(input logic [37:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    adr = a; dat_i = d; sel = s; we = 1'b1; stb = 1'b1;
    @(negedge clk);
    we = 1'b0; stb = 1'b0;
  endtask

  // One-cycle read, checking data and same-cycle ack.
  task automatic rd(input string tag, input logic [37:0] a,
                    input logic [31:0] exp);
    adr = a; we = 1'b0; stb = 1'b1; sel = 4'h0;
    #1;
    chk(tag, dat_o, exp);
    chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
    @(negedge clk);
    stb = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b0; adr = '0; dat_i = '0; sel = '0; we = 1'b0; stb = 1'b0;
    #12;
    chk("ack_idle_rst", {31'd0, ack}, 32'd0);
    stb = 1'b1; #1;
    chk("ack_in_rst", {31'd0, ack}, 32'd1);
    stb = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    rd("rst_r0", 38'd0, 32'h0);
    rd("rst_r1", 38'd1, 32'h0);
    rd("rst_r2", 38'd2, 32'h0);
    rd("rst_r3", 38'd3, 32'h0);

    wr(38'd0, 32'h11000011, 4'hF);
    wr(38'd1, 32'h00222200, 4'hF);
    wr(38'd2, 32'h33330000, 4'hF);
    wr(38'd3, 32'h00004444, 4'hF);
    rd("full_r0", 38'd0, 32'h11000011);
    rd("full_r1", 38'd1, 32'h00222200);
    rd("full_r2", 38'd2, 32'h33330000);
    rd("full_r3", 38'd3, 32'h00004444);

    wr(38'd0, 32'h55000000, 4'h8);
    wr(38'd1, 32'h00660000, 4'h4);
    wr(38'd2, 32'h00007700, 4'h2);
    wr(38'd3, 32'h00660088, 4'h1);
    rd("byte_r0", 38'd0, 32'h55000011);
    rd("byte_r1", 38'd1, 32'h00662200);
    rd("byte_r2", 38'd2, 32'h33337700);
    rd("byte_r3", 38'd3, 32'h00004488);

    wr(38'd4, 32'hDEADBEEF, 4'hF);
    wr(38'h20_0000_0000, 32'hDEADBEEF, 4'hF);
    wr(38'h20_0000_0001, 32'hDEADBEEF, 4'hF);
    rd("unm_a4", 38'd4, 32'h0);
    rd("unm_a2p37", 38'h20_0000_0000, 32'h0);
    rd("unm_r0", 38'd0, 32'h55000011);
    rd("unm_r1", 38'd1, 32'h00662200);
    rd("unm_r2", 38'd2, 32'h33337700);
    rd("unm_r3", 38'd3, 32'h00004488);

    // Held write: several cycles, same value.
    adr = 38'd2; dat_i = 32'hCAFEF00D; sel = 4'hF; we = 1'b1; stb = 1'b1;
    repeat (3) @(negedge clk);
    we = 1'b0; stb = 1'b0;
    rd("held_r2", 38'd2, 32'hCAFEF00D);

    // Read data follows address with stb low.
    adr = 38'd3; #1;
    chk("nostb_r3", dat_o, 32'h00004488);
    chk("nostb_ack", {31'd0, ack}, 32'd0);
    @(negedge clk);

    wr(38'd1, 32'hFFFFFFFF, 4'h0);
    rd("sel0_r1", 38'd1, 32'h00662200);

    // Async reset between edges.
    #2 reset = 1'b0;
    #1;
    adr = 38'd0; #0.5 chk("arst_r0", dat_o, 32'h0);
    adr = 38'd1; #0.5 chk("arst_r1", dat_o, 32'h0);
    adr = 38'd2; #0.5 chk("arst_r2", dat_o, 32'h0);
    adr = 38'd3; #0.5 chk("arst_r3", dat_o, 32'h0);
    @(negedge clk);
    wr(38'd3, 32'h87654321, 4'hF);
    adr = 38'd3; #1;
    chk("rst_wr_ign", dat_o, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    wr(38'd1, 32'hAAAAAAAA, 4'hF);
    adr = 38'd1; dat_i = 32'h12345678; sel = 4'hF; we = 1'b1; stb = 1'b1;
    #1;
    chk("rdw_old", dat_o, 32'hAAAAAAAA);
    @(negedge clk);
    we = 1'b0; stb = 1'b0;
    #1;
    chk("rdw_new", dat_o, 32'h12345678);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
